// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller: round-robin arbitration between fetch and load/store,
// sequencing each request into consecutive byte accesses with little-endian read assembly.
module mem_ctrl #(
   parameter logic [31:0] IO_ADDR_LO = 32'h0003_0000,
   parameter logic [31:0] IO_ADDR_HI = 32'h0003_0004
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic        lsb_wr,
   input  logic [1:0]  lsb_len,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata
);

   typedef enum logic [1:0] {IDLE, IF_RD, LSB_RD, LSB_WR} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d, n_q, n_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [23:0] buf_q, buf_d;
   logic        last_lsb_q, last_lsb_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        if_done_q, if_done_d, lsb_done_q, lsb_done_d;
   logic [31:0] if_data_q, if_data_d, lsb_data_q, lsb_data_d;

   logic [2:0]  lsb_n;
   logic [31:0] wr_addr, rd_word;
   logic [7:0]  wr_byte;
   logic        if_elig, lsb_elig, grant_lsb, acc_blk, wr_blk;

   function automatic logic io_hit(input logic [31:0] a);
      return (a == IO_ADDR_LO) || (a == IO_ADDR_HI);
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      last_lsb_d = last_lsb_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = 1'b0;
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      if_data_d  = if_data_q;
      lsb_data_d = lsb_data_q;

      case (lsb_len)
         2'b00:   lsb_n = 3'd1;
         2'b01:   lsb_n = 3'd2;
         default: lsb_n = 3'd4;
      endcase
      wr_addr = addr_q + {29'd0, cnt_q};
      case (cnt_q[1:0])
         2'd0:    wr_byte = wdata_q[7:0];
         2'd1:    wr_byte = wdata_q[15:8];
         2'd2:    wr_byte = wdata_q[23:16];
         default: wr_byte = wdata_q[31:24];
      endcase
      // The final byte is taken straight from mem_din on the completing edge.
      case (n_q)
         3'd1:    rd_word = {24'd0, mem_din};
         3'd2:    rd_word = {16'd0, mem_din, buf_q[7:0]};
         default: rd_word = {mem_din, buf_q};
      endcase
      acc_blk   = io_buffer_full && io_hit(lsb_addr);
      wr_blk    = io_buffer_full && io_hit(wr_addr);
      if_elig   = if_req && !if_done_q && !clear;
      lsb_elig  = lsb_req && !lsb_done_q && (lsb_wr || !clear);
      grant_lsb = lsb_elig && (!if_elig || !last_lsb_q);

      case (state_q)
         IDLE: begin
            if (grant_lsb) begin
               addr_d     = lsb_addr;
               wdata_d    = lsb_wdata;
               n_d        = lsb_n;
               mem_a_d    = lsb_addr;
               last_lsb_d = 1'b1;
               cnt_d      = '0;
               buf_d      = '0;
               if (lsb_wr) begin
                  state_d = LSB_WR;
                  if (!acc_blk) begin
                     mem_wr_d   = 1'b1;
                     mem_dout_d = lsb_wdata[7:0];
                     cnt_d      = 3'd1;
                     lsb_done_d = (lsb_n == 3'd1);
                  end
               end else begin
                  state_d = LSB_RD;
               end
            end else if (if_elig) begin
               addr_d     = if_addr;
               n_d        = 3'd4;
               mem_a_d    = if_addr;
               last_lsb_d = 1'b0;
               cnt_d      = '0;
               buf_d      = '0;
               state_d    = IF_RD;
            end
         end
         IF_RD, LSB_RD: begin
            if (clear) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q < n_q - 3'd1) mem_a_d = mem_a_q + 32'd1;
               case (cnt_q)
                  3'd1:    buf_d[7:0]   = mem_din;
                  3'd2:    buf_d[15:8]  = mem_din;
                  3'd3:    buf_d[23:16] = mem_din;
                  default: ;
               endcase
               if (cnt_q == n_q) begin
                  state_d = IDLE;
                  if (state_q == IF_RD) begin
                     if_done_d = 1'b1;
                     if_data_d = rd_word;
                  end else begin
                     lsb_done_d = 1'b1;
                     lsb_data_d = rd_word;
                  end
               end
            end
         end
         LSB_WR: begin
            if (cnt_q == n_q) begin
               state_d = IDLE;
            end else begin
               mem_a_d = wr_addr;
               if (!wr_blk) begin
                  mem_wr_d   = 1'b1;
                  mem_dout_d = wr_byte;
                  cnt_d      = cnt_q + 3'd1;
                  lsb_done_d = (cnt_q + 3'd1 == n_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         last_lsb_q <= 1'b0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         if_data_q  <= '0;
         lsb_data_q <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         last_lsb_q <= last_lsb_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         if_done_q  <= if_done_d;
         lsb_done_q <= lsb_done_d;
         if_data_q  <= if_data_d;
         lsb_data_q <= lsb_data_d;
      end
   end

   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   assign mem_wr    = mem_wr_q;
   assign if_done   = if_done_q;
   assign if_data   = if_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_data_q;

endmodule
